// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the branch target buffer: IF lookup, EX resolution
// feedback with redirect, and the statistics counters for the debug display.
interface branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   pc_IF;
  logic              pred_taken_IF;
  logic [XLEN-1:0]   pred_target_IF;

  logic              upd_valid_EX;
  logic [XLEN-1:0]   upd_pc_EX;
  logic              upd_taken_EX;
  logic [XLEN-1:0]   upd_target_EX;
  logic              pred_taken_EX;
  logic [XLEN-1:0]   pred_target_EX;
  logic              mispredict_EX;
  logic [XLEN-1:0]   redirect_pc_EX;

  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispred_cnt;

  // Pipeline side: drives the fetch PC and the resolved branch information.
  modport master (
    output pc_IF, upd_valid_EX, upd_pc_EX, upd_taken_EX, upd_target_EX,
           pred_taken_EX, pred_target_EX,
    input  pred_taken_IF, pred_target_IF, mispredict_EX, redirect_pc_EX,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_IF, upd_valid_EX, upd_pc_EX, upd_taken_EX, upd_target_EX,
           pred_taken_EX, pred_target_EX,
    output pred_taken_IF, pred_target_IF, mispredict_EX, redirect_pc_EX,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters, mispredict
// detection for EX, and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CTR_MAX  = '1;
  localparam logic [CNT_W-1:0]  CTR_ZERO = '0;
  localparam logic [CNT_W-1:0]  CTR_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [XLEN-1:0]   PC_STEP  = XLEN'(4);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [CNT_W-1:0]  ctr_q    [ENTRIES];

  logic [STAT_W-1:0] branch_cnt_q;
  logic [STAT_W-1:0] mispred_cnt_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;

  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;

  logic              tbl_write;
  logic              tbl_valid_d;
  logic [TAG_W-1:0]  tbl_tag_d;
  logic [XLEN-1:0]   tbl_target_d;
  logic [CNT_W-1:0]  tbl_ctr_d;

  logic              mispredict;

  // Word-aligned PCs never use the low two bits for indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_IF[1:0], bus.upd_pc_EX[1:0]};

  // Fetch-side lookup reads only registered table state.
  always_comb begin
    lk_idx             = bus.pc_IF[IDX_W+1:2];
    lk_tag             = bus.pc_IF[XLEN-1:IDX_W+2];
    lk_hit             = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bus.pred_taken_IF  = 1'b0;
    bus.pred_target_IF = bus.pc_IF + PC_STEP;
    if (lk_hit && ctr_q[lk_idx][CNT_W-1]) begin
      bus.pred_taken_IF  = 1'b1;
      bus.pred_target_IF = target_q[lk_idx];
    end
  end

  always_comb begin
    mispredict = bus.upd_valid_EX &&
                 ((bus.upd_taken_EX != bus.pred_taken_EX) ||
                  (bus.upd_taken_EX && (bus.upd_target_EX != bus.pred_target_EX)));
    bus.mispredict_EX  = mispredict;
    bus.redirect_pc_EX = bus.upd_taken_EX ? bus.upd_target_EX
                                          : (bus.upd_pc_EX + PC_STEP);
  end

  // Next contents of the entry addressed by the resolving branch.
  always_comb begin
    up_idx       = bus.upd_pc_EX[IDX_W+1:2];
    up_tag       = bus.upd_pc_EX[XLEN-1:IDX_W+2];
    up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    tbl_write    = 1'b0;
    tbl_valid_d  = valid_q[up_idx];
    tbl_tag_d    = tag_q[up_idx];
    tbl_target_d = target_q[up_idx];
    tbl_ctr_d    = ctr_q[up_idx];
    if (bus.upd_valid_EX) begin
      if (up_hit) begin
        tbl_write = 1'b1;
        if (bus.upd_taken_EX) begin
          tbl_target_d = bus.upd_target_EX;
          if (ctr_q[up_idx] != CTR_MAX) begin
            tbl_ctr_d = ctr_q[up_idx] + CNT_W'(1);
          end
        end else if (ctr_q[up_idx] != CTR_ZERO) begin
          tbl_ctr_d = ctr_q[up_idx] - CNT_W'(1);
        end
      end else if (bus.upd_taken_EX) begin
        // A taken miss claims the slot, evicting any aliasing branch.
        tbl_write    = 1'b1;
        tbl_valid_d  = 1'b1;
        tbl_tag_d    = up_tag;
        tbl_target_d = bus.upd_target_EX;
        tbl_ctr_d    = CTR_WEAK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (tbl_write) begin
      valid_q[up_idx]  <= tbl_valid_d;
      tag_q[up_idx]    <= tbl_tag_d;
      target_q[up_idx] <= tbl_target_d;
      ctr_q[up_idx]    <= tbl_ctr_d;
    end
  end

  // Statistics stick at their maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bus.upd_valid_EX) begin
      if (branch_cnt_q != STAT_MAX) begin
        branch_cnt_q <= branch_cnt_q + STAT_W'(1);
      end
      if (mispredict && (mispred_cnt_q != STAT_MAX)) begin
        mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
      end
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule
